// File: rtl/branch_predictor.sv
// branch_predictor: tagged direct-mapped target buffer with 2-bit counters plus EX-stage branch resolver; define BP_GSHARE_EN for gshare indexing
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int GHR_BITS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_bcond,
  output logic            ex_mispredict,
  output logic [XLEN-1:0] ex_correct_pc
);
  localparam int IDX = $clog2(ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tags    [ENTRIES];
  logic [XLEN-1:0]     targets [ENTRIES];
  logic [1:0]          ctrs    [ENTRIES];
  logic [IDX-1:0]      if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic [1:0]          ctr_q, ctr_nxt;
  logic                is_branch, is_jump, br_cond, hit;
`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;
  assign if_idx = if_pc[IDX+1:2] ^ IDX'(ghr);
  assign ex_idx = ex_pc[IDX+1:2] ^ IDX'(ghr);
  // global history shifts in each resolved conditional branch outcome
  always_ff @(posedge clk) begin
    if (!reset) ghr <= '0;
    else if (is_branch) ghr <= (ghr << 1) | GHR_BITS'(ex_bcond);
  end
`else
  assign if_idx = if_pc[IDX+1:2];
  assign ex_idx = ex_pc[IDX+1:2];
`endif
  assign if_tag = if_pc[TAG_BITS+IDX+1:IDX+2];
  assign ex_tag = ex_pc[TAG_BITS+IDX+1:IDX+2];
  assign hit = valid[if_idx] && tags[if_idx] == if_tag;
  assign pred_taken = hit && ctrs[if_idx][1];
  assign pred_next_pc = pred_taken ? targets[if_idx] : if_pc + XLEN'(4);
  // branch condition evaluation and misprediction detection
  always_comb begin
    br_cond = ex_funct3 == 3'b000 ? ex_rs1 == ex_rs2 :
              ex_funct3 == 3'b001 ? ex_rs1 != ex_rs2 :
              ex_funct3 == 3'b100 ? $signed(ex_rs1) <  $signed(ex_rs2) :
              ex_funct3 == 3'b101 ? $signed(ex_rs1) >= $signed(ex_rs2) :
              ex_funct3 == 3'b110 ? ex_rs1 <  ex_rs2 :
              ex_funct3 == 3'b111 ? ex_rs1 >= ex_rs2 : 1'b0;
    is_branch = ex_valid && ex_opcode == OP_BRANCH && ex_funct3[2:1] != 2'b01;
    is_jump = ex_valid && (ex_opcode == OP_JAL || ex_opcode == OP_JALR);
    ex_bcond = is_jump || (is_branch && br_cond);
    ex_mispredict = ex_valid && ((ex_bcond != ex_pred_taken) || (ex_bcond && ex_pred_target != ex_target));
    ex_correct_pc = ex_bcond ? ex_target : ex_pc + XLEN'(4);
    ctr_q = ctrs[ex_idx];
    ctr_nxt = ex_bcond ? (ctr_q == 2'b11 ? ctr_q : ctr_q + 2'd1) : (ctr_q == 2'b00 ? ctr_q : ctr_q - 2'd1);
  end
  // table training from the EX stage; reset wipes the table and drops any pending update
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrs[i] <= 2'b01;
    end else begin
      if (is_branch) ctrs[ex_idx] <= ctr_nxt;
      if (is_jump) ctrs[ex_idx] <= 2'b11;
      if (ex_bcond) begin
        valid[ex_idx] <= 1'b1;
        tags[ex_idx] <= ex_tag;
        targets[ex_idx] <= ex_target;
      end else if (ex_valid && !is_branch && !is_jump && ex_pred_taken) valid[ex_idx] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized checks of branch_predictor against an entry-level reference model
module tb_branch_predictor;
  localparam int ENTRIES = 64, TAG_BITS = 8, GHR_BITS = 6;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ADDI = 7'b0010011, ALU = 7'b0110011;
  logic clk = 0, reset = 0;
  logic [31:0] if_pc = 0, ex_pc = 0, ex_rs1 = 0, ex_rs2 = 0, ex_target = 0, ex_pred_target = 0;
  logic [31:0] pred_next_pc, ex_correct_pc;
  logic [6:0] ex_opcode = 0;
  logic [2:0] ex_funct3 = 0;
  logic ex_valid = 0, ex_pred_taken = 0, pred_taken, ex_bcond, ex_mispredict;
  int checks = 0, errors = 0;
  bit m_valid [ENTRIES];
  int m_tag [ENTRIES];
  int m_ctr [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int m_ghr = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_bcond(ex_bcond), .ex_mispredict(ex_mispredict),
    .ex_correct_pc(ex_correct_pc)
  );

  function automatic int idx_of(logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return int'(((pc / 4) ^ m_ghr) % ENTRIES);
`else
    return int'((pc / 4) % ENTRIES);
`endif
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % (1 << TAG_BITS));
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
  endfunction

  function automatic logic [31:0] m_next(logic [31:0] pc);
    return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_bcond();
    longint a = longint'($signed(ex_rs1)), b = longint'($signed(ex_rs2));
    longint ua = longint'(ex_rs1), ub = longint'(ex_rs2);
    if (!ex_valid) return 0;
    if (ex_opcode == JAL || ex_opcode == JALR) return 1;
    if (ex_opcode != BR) return 0;
    case (ex_funct3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return a < b;
      3'd5: return a >= b;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_mis();
    bit b = m_bcond();
    return ex_valid && (b != ex_pred_taken || (b && ex_pred_target != ex_target));
  endfunction

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_opcode = op; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic idle();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit b, br, jp;
    int i;
    b = m_bcond();
    i = idx_of(ex_pc);
    br = ex_valid && ex_opcode == BR && ex_funct3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    jp = ex_valid && (ex_opcode == JAL || ex_opcode == JALR);
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
      m_ghr = 0;
    end else begin
      if (br) m_ctr[i] = b ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
      if (jp) m_ctr[i] = 3;
      if (b) begin m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target; end
      else if (ex_valid && !br && !jp && ex_pred_taken) m_valid[i] = 0;
      if (br) m_ghr = (m_ghr * 2 + int'(b)) % (1 << GHR_BITS);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 0; idle(); if_pc = 32'h100;
    tick(); tick();
    reset = 1; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL reset_next_pc got=%h exp=00000104", pred_next_pc); end
    checks++; if (ex_mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%0b exp=0", ex_mispredict); end
  endtask

  task automatic test_beq_train();
    if_pc = 32'h100;
    set_ex(1, 32'h100, BR, 3'd0, 5, 5, 32'h80, 0, 32'h104); #1;
    checks++; if (ex_bcond !== 1'b1) begin errors++; $display("FAIL beq_bcond got=%0b exp=1", ex_bcond); end
    checks++; if (ex_mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict got=%0b exp=1", ex_mispredict); end
    checks++; if (ex_correct_pc !== 32'h80) begin errors++; $display("FAIL beq_correct_pc got=%h exp=00000080", ex_correct_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_no_bypass got=%0b exp=0", pred_taken); end
    tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_trained_taken got=%0b exp=1", pred_taken); end
    checks++; if (pred_next_pc !== 32'h80) begin errors++; $display("FAIL beq_trained_next got=%h exp=00000080", pred_next_pc); end
  endtask

  task automatic test_compare();
    logic [2:0] f3 [8] = '{3'd4, 3'd6, 3'd7, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] a [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 3, 7, 7};
    logic [31:0] b [8] = '{1, 1, 1, 1, 4, 4, 7, 7};
    logic exp [8] = '{1, 0, 1, 0, 0, 1, 0, 0};
    for (int k = 0; k < 8; k++) begin
      set_ex(1, 32'h600, BR, f3[k], a[k], b[k], 32'h900, 0, 32'h604); #1;
      checks++; if (ex_bcond !== exp[k]) begin errors++; $display("FAIL compare_f3_%0d got=%0b exp=%0b", f3[k], ex_bcond, exp[k]); end
      checks++; if (ex_correct_pc !== (exp[k] ? 32'h900 : 32'h604)) begin errors++; $display("FAIL compare_cpc_f3_%0d got=%h", f3[k], ex_correct_pc); end
    end
    idle(); #1;
  endtask

  task automatic test_saturation();
    if_pc = 32'h308;
    for (int k = 0; k < 4; k++) begin
      set_ex(1, 32'h308, BR, 3'd0, 9, 9, 32'h700, m_pred(32'h308), m_next(32'h308)); tick();
    end
    set_ex(1, 32'h308, BR, 3'd1, 9, 9, 32'h700, 1, 32'h700); #1;
    checks++; if (ex_mispredict !== 1'b1) begin errors++; $display("FAIL sat_nt_mispredict got=%0b exp=1", ex_mispredict); end
    tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_one_nt got=%0b exp=1", pred_taken); end
    set_ex(1, 32'h308, BR, 3'd1, 9, 9, 32'h700, 1, 32'h700); tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_two_nt got=%0b exp=0", pred_taken); end
    checks++; if (pred_next_pc !== 32'h30C) begin errors++; $display("FAIL sat_two_nt_next got=%h exp=0000030c", pred_next_pc); end
  endtask

  task automatic test_jumps();
    if_pc = 32'h200;
    set_ex(1, 32'h200, JAL, 3'd0, 0, 0, 32'h400, 0, 32'h204); #1;
    checks++; if (ex_mispredict !== 1'b1) begin errors++; $display("FAIL jal_mispredict got=%0b exp=1", ex_mispredict); end
    checks++; if (ex_correct_pc !== 32'h400) begin errors++; $display("FAIL jal_cpc got=%h exp=00000400", ex_correct_pc); end
    tick(); idle(); #1;
    checks++; if (pred_next_pc !== 32'h400) begin errors++; $display("FAIL jal_trained_next got=%h exp=00000400", pred_next_pc); end
    set_ex(1, 32'h200, JALR, 3'd0, 0, 0, 32'h500, 1, 32'h400); #1;
    checks++; if (ex_mispredict !== 1'b1) begin errors++; $display("FAIL jalr_mispredict got=%0b exp=1", ex_mispredict); end
    checks++; if (ex_correct_pc !== 32'h500) begin errors++; $display("FAIL jalr_cpc got=%h exp=00000500", ex_correct_pc); end
    tick(); idle(); #1;
    checks++; if (pred_next_pc !== 32'h500) begin errors++; $display("FAIL jalr_trained_next got=%h exp=00000500", pred_next_pc); end
  endtask

  task automatic test_alias();
    if_pc = 32'h200;
    set_ex(0, 32'h200, ADDI, 3'd0, 0, 0, 32'h900, 1, 32'h500); #1;
    checks++; if (ex_mispredict !== 1'b0 || ex_bcond !== 1'b0) begin errors++; $display("FAIL alias_bubble got=%0b%0b exp=00", ex_bcond, ex_mispredict); end
    tick(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_bubble_keep got=%0b exp=1", pred_taken); end
    ex_valid = 1; #1;
    checks++; if (ex_mispredict !== 1'b1 || ex_bcond !== 1'b0) begin errors++; $display("FAIL alias_flag got=%0b%0b exp=01", ex_bcond, ex_mispredict); end
    checks++; if (ex_correct_pc !== 32'h204) begin errors++; $display("FAIL alias_cpc got=%h exp=00000204", ex_correct_pc); end
    tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_invalidated got=%0b exp=0", pred_taken); end
  endtask

  task automatic test_reset_mid();
    if_pc = 32'h40;
    set_ex(1, 32'h40, BR, 3'd0, 1, 1, 32'h880, 0, 32'h44); reset = 0; tick();
    reset = 1; idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL resetmid_empty got=%0b exp=0", pred_taken); end
    if_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL resetmid_cleared got=%0b exp=0", pred_taken); end
    if_pc = 32'h40;
    set_ex(1, 32'h40, BR, 3'd0, 1, 1, 32'h880, 0, 32'h44); tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL resetmid_ctr_01 got=%0b exp=1", pred_taken); end
  endtask

  task automatic test_wrap();
    if_pc = 32'hFFFF_FFFC;
    set_ex(1, 32'hFFFF_FFFC, BR, 3'd0, 1, 2, 32'h10, 0, 32'h0); #1;
    checks++; if (pred_next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=00000000", pred_next_pc); end
    checks++; if (ex_correct_pc !== 32'h0 || ex_mispredict !== 1'b0) begin errors++; $display("FAIL wrap_cpc got=%h/%0b exp=00000000/0", ex_correct_pc, ex_mispredict); end
    idle(); #1;
  endtask

  task automatic test_random();
    logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h300, 32'h104, 32'h308, 32'h1_0104, 32'hFFFF_FFFC, 32'h40};
    logic [31:0] vals [5] = '{0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 5};
    logic [6:0] ops [6] = '{BR, BR, JAL, JALR, ADDI, ALU};
    logic [31:0] tgts [4] = '{32'h80, 32'h400, 32'h500, 32'h700};
    logic [31:0] pc;
    bit pt;
    for (int n = 0; n < 500; n++) begin
      pc = pool[$urandom_range(0, 7)];
      if_pc = $urandom_range(0, 2) == 0 ? pc : pool[$urandom_range(0, 7)];
      pt = $urandom_range(0, 3) == 0 ? 1'($urandom_range(0, 1)) : m_pred(pc);
      set_ex($urandom_range(0, 4) != 0, pc, ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
             vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)], tgts[$urandom_range(0, 3)], pt,
             pt ? ($urandom_range(0, 3) == 0 ? tgts[$urandom_range(0, 3)] : m_next(pc)) : pc + 32'd4);
      reset = $urandom_range(0, 60) != 0;
      #1;
      checks++; if (pred_taken !== m_pred(if_pc)) begin errors++; $display("FAIL rnd_pred_taken n=%0d got=%0b exp=%0b", n, pred_taken, m_pred(if_pc)); end
      checks++; if (pred_next_pc !== m_next(if_pc)) begin errors++; $display("FAIL rnd_next_pc n=%0d got=%h exp=%h", n, pred_next_pc, m_next(if_pc)); end
      checks++; if (ex_bcond !== m_bcond()) begin errors++; $display("FAIL rnd_bcond n=%0d got=%0b exp=%0b", n, ex_bcond, m_bcond()); end
      checks++; if (ex_mispredict !== m_mis()) begin errors++; $display("FAIL rnd_mispredict n=%0d got=%0b exp=%0b", n, ex_mispredict, m_mis()); end
      checks++; if (ex_correct_pc !== (m_bcond() ? ex_target : ex_pc + 32'd4)) begin errors++; $display("FAIL rnd_cpc n=%0d got=%h", n, ex_correct_pc); end
      tick();
    end
    reset = 1; idle(); #1;
  endtask

  initial begin
    test_reset();
    test_beq_train();
    test_compare();
    test_saturation();
    test_jumps();
    test_alias();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
